// File: rtl/mips32_arb_pkg.sv
// Shared types and defaults for the MIPS32 single-port memory arbiter.
// Holds the sequencer state encoding, the read-response owner encoding
// and the default address/data widths used by the interface and the top.
package mips32_arb_pkg;

   localparam int AW_DEF = 10;
   localparam int DW_DEF = 32;

   // Sequencer modes: normal running, draining loads/stores, halted for loader
   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      HALT  = 2'd2
   } arb_state_t;

   // Which requester the read data returning next cycle belongs to
   typedef enum logic [1:0] {
      NONE = 2'd0,
      IF   = 2'd1,
      MEM  = 2'd2,
      LD   = 2'd3
   } owner_t;

endpackage

// File: rtl/mips32_mem_arbiter_if.sv
// Bus bundle between the pipeline requesters, the loader, the halt control
// and the shared synchronous-read memory. The slave modport is the arbiter
// view; the master modport is the view of everything around it.
interface mips32_mem_arbiter_if
   import mips32_arb_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
);
   // instruction fetch
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_rvalid;
   logic [DW-1:0] if_rdata;
   // load/store
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_gnt;
   logic          mem_rvalid;
   logic [DW-1:0] mem_rdata;
   // loader / debug
   logic          ld_req;
   logic          ld_we;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_wdata;
   logic          ld_gnt;
   logic          ld_rvalid;
   logic [DW-1:0] ld_rdata;
   // halt sequencing
   logic          halt_req;
   logic          halted;
   // memory port
   logic          ram_en;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   modport slave (
      input  if_req, if_addr,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      input  ld_req, ld_we, ld_addr, ld_wdata,
      input  halt_req, ram_rdata,
      output if_gnt, if_rvalid, if_rdata,
      output mem_gnt, mem_rvalid, mem_rdata,
      output ld_gnt, ld_rvalid, ld_rdata,
      output halted, ram_en, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output if_req, if_addr,
      output mem_req, mem_we, mem_addr, mem_wdata,
      output ld_req, ld_we, ld_addr, ld_wdata,
      output halt_req, ram_rdata,
      input  if_gnt, if_rvalid, if_rdata,
      input  mem_gnt, mem_rvalid, mem_rdata,
      input  ld_gnt, ld_rvalid, ld_rdata,
      input  halted, ram_en, ram_we, ram_addr, ram_wdata
   );

endinterface

// File: rtl/mips32_arb_starve_cnt.sv
// Saturating up-counter with synchronous clear. Used both as the IF
// starvation counter and as the optional performance counters.
// Clear has priority over increment; the count sticks at MAX.
module mips32_arb_starve_cnt #(
   parameter int           W   = 4,
   parameter logic [W-1:0] MAX = '1
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count,
   output logic         max_hit
);

   logic [W-1:0] count_reg;

   // Count up on inc until MAX is reached, clear wins over inc
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (inc && (count_reg != MAX)) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign count   = count_reg;
   assign max_hit = (count_reg == MAX);

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Single-port memory arbiter and halt sequencer for the MIPS32 core.
// Shares one synchronous-read memory between fetch, load/store and the
// loader port, and walks the core RUN -> DRAIN -> HALT so the loader can
// own memory. Grants and the memory command are combinational; read data
// is steered one cycle later by a registered response owner.
// Optional build macro: MIPS32_ARB_PERF_EN adds stall/access counters.
module mips32_mem_arbiter
   import mips32_arb_pkg::*;
#(
   parameter int AW       = AW_DEF,
   parameter int DW       = DW_DEF,
   parameter int MAX_WAIT = 4
)(
   input  logic        clk,
   input  logic        rst_n,
`ifdef MIPS32_ARB_PERF_EN
   input  logic        perf_clr,
   output logic [15:0] perf_if_stall,
   output logic [15:0] perf_mem_acc,
`endif
   mips32_mem_arbiter_if.slave bus
);

   arb_state_t    state_reg, state_next;
   owner_t        owner_reg, owner_next;

   logic          gnt_if, gnt_mem, gnt_ld;
   logic          cmd_en, cmd_we;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rd_issue;
   logic          starve_inc, starve_hit;
   logic [3:0]    unused_starve_cnt;

   // Pick at most one winner this cycle; reset holds every grant low
   always_comb begin
      gnt_if  = 1'b0;
      gnt_mem = 1'b0;
      gnt_ld  = 1'b0;
      if (rst_n) begin
         case (state_reg)
            RUN: begin
               if (bus.mem_req && !(bus.if_req && starve_hit)) gnt_mem = 1'b1;
               else if (bus.if_req)                            gnt_if  = 1'b1;
            end
            DRAIN:   gnt_mem = bus.mem_req;
            HALT:    gnt_ld  = bus.ld_req;
            default: ;
         endcase
      end
   end

   // Drive the memory command straight from the winner
   always_comb begin
      cmd_en    = 1'b0;
      cmd_we    = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      if (gnt_mem) begin
         cmd_en    = 1'b1;
         cmd_we    = bus.mem_we;
         cmd_addr  = bus.mem_addr;
         cmd_wdata = bus.mem_wdata;
      end else if (gnt_if) begin
         cmd_en    = 1'b1;
         cmd_addr  = bus.if_addr;
      end else if (gnt_ld) begin
         cmd_en    = 1'b1;
         cmd_we    = bus.ld_we;
         cmd_addr  = bus.ld_addr;
         cmd_wdata = bus.ld_wdata;
      end
   end

   // A read issued now still owes its data next cycle
   assign rd_issue = cmd_en && !cmd_we;

   // Next mode and the owner of next cycle's read data
   always_comb begin
      state_next = state_reg;
      owner_next = NONE;
      case (state_reg)
         RUN: begin
            if (bus.halt_req) state_next = DRAIN;
         end
         DRAIN: begin
            if (!bus.halt_req)                     state_next = RUN;
            else if (!bus.mem_req && !rd_issue)    state_next = HALT;
         end
         HALT: begin
            if (!bus.halt_req && !rd_issue)        state_next = RUN;
         end
         default: state_next = RUN;
      endcase
      if (gnt_if)                      owner_next = IF;
      else if (gnt_mem && !bus.mem_we) owner_next = MEM;
      else if (gnt_ld && !bus.ld_we)   owner_next = LD;
   end

   // Mode and response-owner registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= RUN;
         owner_reg <= NONE;
      end else begin
         state_reg <= state_next;
         owner_reg <= owner_next;
      end
   end

   // IF starves only while running; any IF grant restarts the streak
   assign starve_inc = (state_reg == RUN) && bus.if_req && !gnt_if;

   mips32_arb_starve_cnt #(
      .W   (4),
      .MAX (4'(MAX_WAIT))
   ) u_starve (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (starve_inc),
      .clr     (gnt_if),
      .count   (unused_starve_cnt),
      .max_hit (starve_hit)
   );

   // Per-requester response path: index 0 = IF, 1 = MEM, 2 = LD
   logic [2:0]    rvalid_vec;
   logic [DW-1:0] rdata_vec [3];

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_resp
         logic [DW-1:0] hold_reg;

         assign rvalid_vec[gi] = rst_n && (owner_reg == owner_t'(2'(gi + 1)));

         // Keep the last delivered word so rdata holds between responses
         always_ff @(posedge clk) begin
            if (!rst_n)              hold_reg <= '0;
            else if (rvalid_vec[gi]) hold_reg <= bus.ram_rdata;
         end

         assign rdata_vec[gi] = rvalid_vec[gi] ? bus.ram_rdata : hold_reg;
      end
   endgenerate

   assign bus.if_gnt     = gnt_if;
   assign bus.mem_gnt    = gnt_mem;
   assign bus.ld_gnt     = gnt_ld;
   assign bus.if_rvalid  = rvalid_vec[0];
   assign bus.mem_rvalid = rvalid_vec[1];
   assign bus.ld_rvalid  = rvalid_vec[2];
   assign bus.if_rdata   = rdata_vec[0];
   assign bus.mem_rdata  = rdata_vec[1];
   assign bus.ld_rdata   = rdata_vec[2];
   assign bus.halted     = rst_n && (state_reg == HALT);
   assign bus.ram_en     = cmd_en;
   assign bus.ram_we     = cmd_we;
   assign bus.ram_addr   = cmd_addr;
   assign bus.ram_wdata  = cmd_wdata;

`ifdef MIPS32_ARB_PERF_EN
   logic unused_stall_sat, unused_acc_sat;

   mips32_arb_starve_cnt #(
      .W   (16),
      .MAX (16'hFFFF)
   ) u_perf_stall (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (bus.if_req && !gnt_if),
      .clr     (perf_clr),
      .count   (perf_if_stall),
      .max_hit (unused_stall_sat)
   );

   mips32_arb_starve_cnt #(
      .W   (16),
      .MAX (16'hFFFF)
   ) u_perf_acc (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (gnt_mem),
      .clr     (perf_clr),
      .count   (perf_mem_acc),
      .max_hit (unused_acc_sat)
   );
`endif

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Self-checking bench for mips32_mem_arbiter. A behavioural model decides
// each cycle's winner from the arbitration rules, keeps a shadow copy of
// memory and queues the expected read responses; a separate monitor pops
// the queue whenever a response is due and compares it with the DUT.
`timescale 1ns/1ps
module tb_mips32_mem_arbiter;

   localparam int AW       = 10;
   localparam int DW       = 32;
   localparam int MAX_WAIT = 4;
   localparam int DEPTH    = 1 << AW;

   localparam int M_RUN   = 0;
   localparam int M_DRAIN = 1;
   localparam int M_HALT  = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mips32_mem_arbiter_if #(.AW(AW), .DW(DW)) bus();

   mips32_mem_arbiter #(
      .AW       (AW),
      .DW       (DW),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic [31:0] init_word(input int i);
      if (i == 5) return 32'h2801000a;
      return 32'hA5A50000 ^ (i * 32'h01010101);
   endfunction

   // Synchronous-read memory behind the arbiter
   logic [DW-1:0] ram [DEPTH];
   logic          ram_loaded = 1'b0;
   always @(posedge clk) begin
      if (!ram_loaded) begin
         for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
         ram_loaded <= 1'b1;
      end else if (bus.ram_en) begin
         if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
         else            bus.ram_rdata <= ram[bus.ram_addr];
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int          who;   // 1 IF, 2 MEM, 3 LD
      logic [31:0] data;
      int          due;
   } resp_t;

   resp_t       exp_q[$];
   logic [31:0] shadow [DEPTH];
   int          mode   = M_RUN;
   int          denied = 0;     // consecutive RUN cycles IF asked and lost
   int          exp_win;        // 0 none, 1 IF, 2 MEM, 3 LD
   bit          exp_read;
   bit          exp_halted;

   task automatic model_eval();
      exp_win    = 0;
      exp_read   = 1'b0;
      exp_halted = 1'b0;
      if (!rst_n) begin
         exp_q.delete();
         return;
      end
      exp_halted = (mode == M_HALT);
      if (mode == M_RUN) begin
         if (bus.mem_req && !(bus.if_req && denied >= MAX_WAIT)) exp_win = 2;
         else if (bus.if_req) exp_win = 1;
      end else if (mode == M_DRAIN) begin
         if (bus.mem_req) exp_win = 2;
      end else begin
         if (bus.ld_req) exp_win = 3;
      end
      case (exp_win)
         1: begin
            exp_read = 1'b1;
            exp_q.push_back('{who: 1, data: shadow[bus.if_addr], due: cyc + 1});
         end
         2: begin
            if (bus.mem_we) shadow[bus.mem_addr] = bus.mem_wdata;
            else begin
               exp_read = 1'b1;
               exp_q.push_back('{who: 2, data: shadow[bus.mem_addr], due: cyc + 1});
            end
         end
         3: begin
            if (bus.ld_we) shadow[bus.ld_addr] = bus.ld_wdata;
            else begin
               exp_read = 1'b1;
               exp_q.push_back('{who: 3, data: shadow[bus.ld_addr], due: cyc + 1});
            end
         end
         default: ;
      endcase
   endtask

   task automatic model_commit();
      if (!rst_n) begin
         mode   = M_RUN;
         denied = 0;
         return;
      end
      if (exp_win == 1) denied = 0;
      else if (mode == M_RUN && bus.if_req && denied < MAX_WAIT) denied++;
      case (mode)
         M_RUN:   if (bus.halt_req) mode = M_DRAIN;
         M_DRAIN: begin
            if (!bus.halt_req) mode = M_RUN;
            else if (!bus.mem_req && !exp_read) mode = M_HALT;
         end
         default: if (!bus.halt_req && !exp_read) mode = M_RUN;
      endcase
   endtask

   // One clock of stimulus: predict, check grants mid-cycle, advance model
   task automatic run_cycle();
      model_eval();
      @(negedge clk);
      chk("if_gnt",  bus.if_gnt,  exp_win == 1);
      chk("mem_gnt", bus.mem_gnt, exp_win == 2);
      chk("ld_gnt",  bus.ld_gnt,  exp_win == 3);
      chk("ram_en",  bus.ram_en,  exp_win != 0);
      chk("halted",  bus.halted,  exp_halted);
      if (exp_win != 0)
         $display("cyc %0d grant=%0d we=%0b addr=%h", cyc, exp_win, bus.ram_we, bus.ram_addr);
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic set_all(input logic v);
      bus.if_req  = v;
      bus.mem_req = v;
      bus.ld_req  = v;
      bus.mem_we  = 1'b0;
      bus.ld_we   = 1'b0;
   endtask

   task automatic rand_reqs(input int p_if, input int p_mem, input int p_ld);
      bus.if_req    = ($urandom_range(0, 99) < p_if);
      bus.if_addr   = 10'($urandom_range(0, 15));
      bus.mem_req   = ($urandom_range(0, 99) < p_mem);
      bus.mem_we    = 1'($urandom_range(0, 1));
      bus.mem_addr  = 10'($urandom_range(0, 15));
      bus.mem_wdata = $urandom;
      bus.ld_req    = ($urandom_range(0, 99) < p_ld);
      bus.ld_we     = 1'($urandom_range(0, 1));
      bus.ld_addr   = 10'($urandom_range(0, 15));
      bus.ld_wdata  = $urandom;
   endtask

   // Response monitor: every falling edge, compare against the queue head
   initial begin
      resp_t      e;
      logic [2:0] got;
      forever begin
         @(negedge clk);
         got = {bus.ld_rvalid, bus.mem_rvalid, bus.if_rvalid};
         if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk("rvalid_owner", 32'(got), 32'(3'b001 << (e.who - 1)));
            case (e.who)
               1:       chk("if_rdata",  bus.if_rdata,  e.data);
               2:       chk("mem_rdata", bus.mem_rdata, e.data);
               default: chk("ld_rdata",  bus.ld_rdata,  e.data);
            endcase
         end else begin
            chk("rvalid_idle", 32'(got), 32'd0);
         end
      end
   end

   // Stimulus
   initial begin
      for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
      bus.halt_req  = 1'b0;
      bus.if_addr   = '0;
      bus.mem_addr  = '0;
      bus.ld_addr   = '0;
      bus.mem_wdata = '0;
      bus.ld_wdata  = '0;
      set_all(1'b1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;

      // reset with every request asserted
      repeat (2) run_cycle();
      rst_n = 1'b1;
      set_all(1'b0);
      run_cycle();

      // IF-only read of the preloaded word
      bus.if_req  = 1'b1;
      bus.if_addr = 10'd5;
      run_cycle();
      bus.if_req  = 1'b0;
      run_cycle();

      // continuous IF vs MEM contention
      bus.if_req   = 1'b1;
      bus.mem_req  = 1'b1;
      bus.mem_we   = 1'b0;
      bus.mem_addr = 10'd3;
      repeat (15) run_cycle();
      set_all(1'b0);
      run_cycle();

      // random running traffic
      repeat (200) begin
         rand_reqs(60, 60, 50);
         run_cycle();
      end

      // halt with loads/stores still in flight
      bus.halt_req = 1'b1;
      bus.if_req   = 1'b1;
      bus.mem_req  = 1'b1;
      bus.mem_we   = 1'b0;
      bus.mem_addr = 10'd7;
      repeat (2) run_cycle();
      bus.mem_req  = 1'b0;
      repeat (4) run_cycle();

      // loader write then read-back while fetch keeps asking
      bus.ld_req   = 1'b1;
      bus.ld_we    = 1'b1;
      bus.ld_addr  = 10'd8;
      bus.ld_wdata = 32'hfc000000;
      run_cycle();
      bus.ld_we    = 1'b0;
      run_cycle();
      bus.ld_req   = 1'b0;
      run_cycle();
      repeat (40) begin
         rand_reqs(50, 30, 70);
         run_cycle();
      end

      // resume
      bus.halt_req = 1'b0;
      bus.ld_req   = 1'b0;
      bus.mem_req  = 1'b0;
      bus.if_req   = 1'b1;
      repeat (3) run_cycle();

      // mixed random traffic with halt_req toggling
      repeat (500) begin
         rand_reqs(60, 50, 60);
         if ($urandom_range(0, 99) < 6) bus.halt_req = ~bus.halt_req;
         run_cycle();
      end

      // reset in the cycle after a read grant
      bus.halt_req = 1'b0;
      set_all(1'b0);
      repeat (3) run_cycle();
      bus.if_req  = 1'b1;
      bus.if_addr = 10'd5;
      run_cycle();
      rst_n = 1'b0;
      repeat (2) run_cycle();
      rst_n = 1'b1;
      bus.if_req = 1'b0;
      repeat (3) run_cycle();

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
